// File: rtl/icetap_pkg.sv
// Shared encodings for the icetap capture engine: FSM states and per-signal mask codes.
package icetap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRE_TRIG  = 2'd1,
        ST_POST_TRIG = 2'd2
    } state_e;

    localparam logic [2:0] MASK_DC   = 3'd0;
    localparam logic [2:0] MASK_LO   = 3'd1;
    localparam logic [2:0] MASK_HI   = 3'd2;
    localparam logic [2:0] MASK_RISE = 3'd3;
    localparam logic [2:0] MASK_FALL = 3'd4;
    localparam logic [2:0] MASK_EDGE = 3'd5;

endpackage

// File: rtl/icetap_capture_ctrl_if.sv
// Capture engine outputs: RAM write port plus the status reported to the scan interface.
interface icetap_capture_ctrl_if #(
    parameter int unsigned NR_SIGNALS = 16,
    parameter int unsigned ADDR_BITS  = 8
);
    logic [1:0]            state;
    logic [ADDR_BITS-1:0]  start_addr;
    logic [ADDR_BITS-1:0]  trigger_addr;
    logic [ADDR_BITS-1:0]  stop_addr;
    logic                  ram_wr_ena;
    logic [ADDR_BITS-1:0]  ram_wr_addr;
    logic [NR_SIGNALS-1:0] ram_wr_data;

    modport master (
        output state, start_addr, trigger_addr, stop_addr,
        output ram_wr_ena, ram_wr_addr, ram_wr_data
    );

    modport slave (
        input state, start_addr, trigger_addr, stop_addr,
        input ram_wr_ena, ram_wr_addr, ram_wr_data
    );
endinterface

// File: rtl/icetap_sig_match.sv
// Evaluates one 3-bit mask code against a signal's current and previous value.
module icetap_sig_match
    import icetap_pkg::*;
(
    input  logic [2:0] code,
    input  logic       cur,
    input  logic       prev,
    output logic       match
);
    always_comb begin
        match = 1'b1;
        case (code)
            MASK_LO:   match = ~cur;
            MASK_HI:   match = cur;
            MASK_RISE: match = ~prev & cur;
            MASK_FALL: match = prev & ~cur;
            MASK_EDGE: match = prev ^ cur;
            default:   match = 1'b1;
        endcase
    end
endmodule

// File: rtl/icetap_capture_ctrl.sv
// Recording engine: evaluates store/trigger conditions each src_clk cycle and drives the
// circular sample RAM write port.
module icetap_capture_ctrl
    import icetap_pkg::*;
#(
    parameter int unsigned NR_SIGNALS         = 16,
    parameter int unsigned RECORD_DEPTH       = 256,
    parameter int unsigned POST_TRIGGER_DEPTH = 128
) (
    input  logic                    src_clk,
    input  logic                    src_reset_,
    input  logic [NR_SIGNALS-1:0]   signals_in,
    input  logic                    start,
    input  logic                    store_always,
    input  logic                    trigger_always,
    input  logic [NR_SIGNALS*3-1:0] store_mask_vec,
    input  logic [NR_SIGNALS*3-1:0] trigger_mask_vec,
    icetap_capture_ctrl_if.master   cap
);
    localparam int unsigned RAM_ADDR_BITS = $clog2(RECORD_DEPTH);

    typedef logic [RAM_ADDR_BITS-1:0] addr_t;
    typedef logic [RAM_ADDR_BITS:0]   cnt_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(RECORD_DEPTH);
    localparam cnt_t POST_CNT  = cnt_t'(POST_TRIGGER_DEPTH);

    state_e                state_q, state_d;
    addr_t                 wr_ptr_q, wr_ptr_d;
    cnt_t                  fill_cnt_q, fill_cnt_d;
    cnt_t                  post_cnt_q, post_cnt_d;
    addr_t                 start_addr_q, start_addr_d;
    addr_t                 trigger_addr_q, trigger_addr_d;
    addr_t                 stop_addr_q, stop_addr_d;
    logic                  wr_ena_q, wr_ena_d;
    addr_t                 wr_addr_q, wr_addr_d;
    logic [NR_SIGNALS-1:0] wr_data_q;
    logic [NR_SIGNALS-1:0] sig_d_q;

    logic [NR_SIGNALS-1:0] store_match, trig_match;
    logic                  store_hit, trig_hit, do_write;

    for (genvar i = 0; i < NR_SIGNALS; i++) begin : g_match
        icetap_sig_match u_store (
            .code  (store_mask_vec[3*i +: 3]),
            .cur   (signals_in[i]),
            .prev  (sig_d_q[i]),
            .match (store_match[i])
        );
        icetap_sig_match u_trig (
            .code  (trigger_mask_vec[3*i +: 3]),
            .cur   (signals_in[i]),
            .prev  (sig_d_q[i]),
            .match (trig_match[i])
        );
    end

    assign store_hit = store_always | (&store_match);
    assign trig_hit  = trigger_always | (&trig_match);

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        fill_cnt_d     = fill_cnt_q;
        post_cnt_d     = post_cnt_q;
        start_addr_d   = start_addr_q;
        trigger_addr_d = trigger_addr_q;
        stop_addr_d    = stop_addr_q;
        wr_addr_d      = wr_ptr_q;
        wr_ena_d       = 1'b0;
        do_write       = 1'b0;

        if (start) begin
            // The start-cycle sample is deliberately not evaluated.
            state_d        = ST_PRE_TRIG;
            wr_ptr_d       = '0;
            fill_cnt_d     = '0;
            post_cnt_d     = '0;
            start_addr_d   = '0;
            trigger_addr_d = '0;
            stop_addr_d    = '0;
        end else begin
            unique case (state_q)
                ST_PRE_TRIG: begin
                    if (trig_hit) begin
                        do_write       = 1'b1;
                        trigger_addr_d = wr_ptr_q;
                        post_cnt_d     = '0;
                        state_d        = ST_POST_TRIG;
                    end else if (store_hit) begin
                        do_write = 1'b1;
                    end
                end
                ST_POST_TRIG: begin
                    if (store_hit) begin
                        do_write   = 1'b1;
                        post_cnt_d = post_cnt_q + cnt_t'(1);
                        if (post_cnt_d == POST_CNT) begin
                            stop_addr_d = wr_ptr_q;
                            state_d     = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase

            if (do_write) begin
                wr_ena_d = 1'b1;
                wr_ptr_d = wr_ptr_q + addr_t'(1);
                if (fill_cnt_q < DEPTH_CNT) begin
                    fill_cnt_d = fill_cnt_q + cnt_t'(1);
                end else begin
                    // Buffer full: this write evicts the oldest sample.
                    start_addr_d = wr_ptr_q + addr_t'(1);
                end
            end
        end
    end

    always_ff @(posedge src_clk or negedge src_reset_) begin
        if (!src_reset_) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            fill_cnt_q     <= '0;
            post_cnt_q     <= '0;
            start_addr_q   <= '0;
            trigger_addr_q <= '0;
            stop_addr_q    <= '0;
            wr_ena_q       <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            sig_d_q        <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            fill_cnt_q     <= fill_cnt_d;
            post_cnt_q     <= post_cnt_d;
            start_addr_q   <= start_addr_d;
            trigger_addr_q <= trigger_addr_d;
            stop_addr_q    <= stop_addr_d;
            wr_ena_q       <= wr_ena_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= signals_in;
            sig_d_q        <= signals_in;
        end
    end

    assign cap.state        = state_q;
    assign cap.start_addr   = start_addr_q;
    assign cap.trigger_addr = trigger_addr_q;
    assign cap.stop_addr    = stop_addr_q;
    assign cap.ram_wr_ena   = wr_ena_q;
    assign cap.ram_wr_addr  = wr_addr_q;
    assign cap.ram_wr_data  = wr_data_q;
endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Directed bench for icetap_capture_ctrl (4 signals, depth 16, 8 post-trigger samples).
module tb_icetap_capture_ctrl;
    localparam int unsigned NS  = 4;
    localparam int unsigned RD  = 16;
    localparam int unsigned PTD = 8;
    localparam int unsigned AB  = 4;

    logic          src_clk = 1'b0;
    logic          src_reset_;
    logic [NS-1:0] signals_in;
    logic          start;
    logic          store_always;
    logic          trigger_always;
    logic [NS*3-1:0] store_mask_vec;
    logic [NS*3-1:0] trigger_mask_vec;

    int total = 0;
    int bad   = 0;
    int cnt;

    always #5 src_clk = ~src_clk;

    icetap_capture_ctrl_if #(.NR_SIGNALS(NS), .ADDR_BITS(AB)) cap ();

    icetap_capture_ctrl #(
        .NR_SIGNALS         (NS),
        .RECORD_DEPTH       (RD),
        .POST_TRIGGER_DEPTH (PTD)
    ) dut (
        .src_clk          (src_clk),
        .src_reset_       (src_reset_),
        .signals_in       (signals_in),
        .start            (start),
        .store_always     (store_always),
        .trigger_always   (trigger_always),
        .store_mask_vec   (store_mask_vec),
        .trigger_mask_vec (trigger_mask_vec),
        .cap              (cap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge src_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        src_reset_       = 1'b0;
        signals_in       = '0;
        start            = 1'b0;
        store_always     = 1'b0;
        trigger_always   = 1'b0;
        store_mask_vec   = '0;
        trigger_mask_vec = '0;

        // Reset and idle
        #3;
        check("rst_state", 32'(cap.state), 0);
        check("rst_ena", 32'(cap.ram_wr_ena), 0);
        repeat (2) tick();
        src_reset_ = 1'b1;
        check("idle_state", 32'(cap.state), 0);
        check("idle_start_addr", 32'(cap.start_addr), 0);
        check("idle_trig_addr", 32'(cap.trigger_addr), 0);
        check("idle_stop_addr", 32'(cap.stop_addr), 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cap.ram_wr_ena) cnt++;
        end
        check("idle_no_writes", 32'(cnt), 0);

        // Immediate trigger: trigger at 0, then 8 post samples
        store_always   = 1'b1;
        trigger_always = 1'b1;
        pulse_start();
        check("t2_start_state", 32'(cap.state), 1);
        check("t2_start_ena", 32'(cap.ram_wr_ena), 0);
        tick();
        check("t2_trig_state", 32'(cap.state), 2);
        check("t2_trig_ena", 32'(cap.ram_wr_ena), 1);
        check("t2_trig_wr_addr", 32'(cap.ram_wr_addr), 0);
        check("t2_trig_addr", 32'(cap.trigger_addr), 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("t2_post_ena", 32'(cap.ram_wr_ena), 1);
            check("t2_post_addr", 32'(cap.ram_wr_addr), 32'(i));
        end
        check("t2_done_state", 32'(cap.state), 0);
        check("t2_stop_addr", 32'(cap.stop_addr), 8);
        check("t2_start_addr", 32'(cap.start_addr), 0);
        tick();
        check("t2_idle_ena", 32'(cap.ram_wr_ena), 0);

        // Rising-edge trigger after 20 pre-trigger samples, buffer wraps
        trigger_always   = 1'b0;
        trigger_mask_vec = 12'h003;
        signals_in       = 4'b0000;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t3_pre_addr", 32'(cap.ram_wr_addr), 32'(i % 16));
        end
        check("t3_pre_state", 32'(cap.state), 1);
        check("t3_pre_start_addr", 32'(cap.start_addr), 4);
        signals_in = 4'b0001;
        tick();
        check("t3_trig_ena", 32'(cap.ram_wr_ena), 1);
        check("t3_trig_wr_addr", 32'(cap.ram_wr_addr), 4);
        check("t3_trig_data", 32'(cap.ram_wr_data), 1);
        check("t3_trig_addr", 32'(cap.trigger_addr), 4);
        check("t3_trig_state", 32'(cap.state), 2);
        check("t3_trig_start_addr", 32'(cap.start_addr), 5);
        for (int i = 5; i <= 12; i++) begin
            tick();
            check("t3_post_addr", 32'(cap.ram_wr_addr), 32'(i));
        end
        check("t3_done_state", 32'(cap.state), 0);
        check("t3_stop_addr", 32'(cap.stop_addr), 12);
        check("t3_start_addr", 32'(cap.start_addr), 13);

        // Restart from POST_TRIG after 3 post samples
        trigger_mask_vec = 12'h002;
        signals_in       = 4'b0000;
        pulse_start();
        repeat (2) tick();
        check("t5_pre_addr", 32'(cap.ram_wr_addr), 1);
        signals_in = 4'b0001;
        tick();
        check("t5_trig_addr", 32'(cap.trigger_addr), 2);
        repeat (3) tick();
        check("t5_post_state", 32'(cap.state), 2);
        check("t5_post_addr", 32'(cap.ram_wr_addr), 5);
        pulse_start();
        check("t5_rs_state", 32'(cap.state), 1);
        check("t5_rs_ena", 32'(cap.ram_wr_ena), 0);
        check("t5_rs_trig_addr", 32'(cap.trigger_addr), 0);
        check("t5_rs_start_addr", 32'(cap.start_addr), 0);
        check("t5_rs_stop_addr", 32'(cap.stop_addr), 0);
        tick();
        check("t5_rs_wr_ena", 32'(cap.ram_wr_ena), 1);
        check("t5_rs_wr_addr", 32'(cap.ram_wr_addr), 0);

        // Store on bit1 high only, trigger never fires (bit3 held low)
        store_always     = 1'b0;
        store_mask_vec   = 12'h010;
        trigger_mask_vec = 12'h400;
        signals_in       = 4'b0000;
        pulse_start();
        cnt = 0;
        repeat (3) begin
            tick();
            if (cap.ram_wr_ena) cnt++;
        end
        check("t4_low_no_writes", 32'(cnt), 0);
        signals_in = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hi_ena", 32'(cap.ram_wr_ena), 1);
            check("t4_hi_addr", 32'(cap.ram_wr_addr), 32'(i));
        end
        signals_in = 4'b0000;
        tick();
        check("t4_gap_ena", 32'(cap.ram_wr_ena), 0);
        tick();
        signals_in = 4'b0010;
        for (int i = 3; i < 5; i++) begin
            tick();
            check("t4_hi2_addr", 32'(cap.ram_wr_addr), 32'(i));
        end
        signals_in = 4'b0000;
        tick();
        check("t4_end_ena", 32'(cap.ram_wr_ena), 0);
        check("t4_end_state", 32'(cap.state), 1);

        // Asynchronous reset mid PRE_TRIG
        store_always = 1'b1;
        pulse_start();
        repeat (3) tick();
        check("t6_pre_addr", 32'(cap.ram_wr_addr), 2);
        check("t6_pre_ena", 32'(cap.ram_wr_ena), 1);
        #2;
        src_reset_ = 1'b0;
        #1;
        check("t6_rst_state", 32'(cap.state), 0);
        check("t6_rst_ena", 32'(cap.ram_wr_ena), 0);
        check("t6_rst_addr", 32'(cap.ram_wr_addr), 0);
        @(negedge src_clk);
        src_reset_ = 1'b1;
        cnt = 0;
        repeat (10) begin
            tick();
            if (cap.ram_wr_ena) cnt++;
        end
        check("t6_post_rst_no_writes", 32'(cnt), 0);
        check("t6_post_rst_state", 32'(cap.state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
